// File: rtl/lcd_bus_decoder.sv
// Display-side receiver for the 4-bit HD44780 LCD bus. It rebuilds command and data
// bytes, follows the DDRAM address, and flags short strobes and missing low nibbles.
module lcd_bus_decoder #(
  parameter int unsigned MIN_E_HIGH  = 4,
  parameter int unsigned NIB_TIMEOUT = 65535
) (
  input  logic       CCLK,
  input  logic       rst,
  input  logic       LCDE,
  input  logic       LCDRS,
  input  logic       LCDRW,
  input  logic [3:0] LCDDAT,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic       mode4,
  output logic [6:0] ddram_addr,
  output logic       read_seen,
  output logic       err_width,
  output logic       err_timeout
);

  localparam int unsigned WW = $clog2(MIN_E_HIGH + 1);
  localparam int unsigned TW = $clog2(NIB_TIMEOUT + 1);

  typedef enum logic [1:0] {MODE8, M4_HI, M4_LO} state_t;

  state_t          state;
  logic            e_s1, e_s2, e_s3;
  logic            rs_s1, rs_s2, rw_s1, rw_s2;
  logic [3:0]      dat_s1, dat_s2;
  logic [WW-1:0]   wcnt;
  logic [TW-1:0]   tcnt;
  logic [3:0]      hi;
  logic            pend_rs;

  logic            fall, accept, short_e, wr, rd, done, nrs;
  logic [7:0]      nbyte;
  logic [6:0]      naddr;

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      {e_s1, e_s2, e_s3}     <= '0;
      {rs_s1, rs_s2}         <= '0;
      {rw_s1, rw_s2}         <= '0;
      {dat_s1, dat_s2}       <= '0;
      wcnt                   <= '0;
    end else begin
      e_s1   <= LCDE;   e_s2   <= e_s1;  e_s3 <= e_s2;
      rs_s1  <= LCDRS;  rs_s2  <= rs_s1;
      rw_s1  <= LCDRW;  rw_s2  <= rw_s1;
      dat_s1 <= LCDDAT; dat_s2 <= dat_s1;
      if (!e_s2)
        wcnt <= '0;
      else if (wcnt != WW'(MIN_E_HIGH))
        wcnt <= wcnt + 1'b1;
    end
  end

  always_comb begin
    fall    = e_s3 & ~e_s2;
    accept  = fall && (wcnt >= WW'(MIN_E_HIGH));
    short_e = fall && !accept;
    wr      = accept & ~rw_s2;
    rd      = accept & rw_s2;
    done    = wr && (state == MODE8 || state == M4_LO);
    nbyte   = (state == MODE8) ? {dat_s2, 4'h0} : {hi, dat_s2};
    nrs     = (state == MODE8) ? rs_s2 : pend_rs;
    naddr   = ddram_addr;
    if (nrs)
      naddr = ddram_addr + 7'd1;
    else if (nbyte[7])
      naddr = nbyte[6:0];
    else if (nbyte == 8'h01 || nbyte == 8'h02 || nbyte == 8'h03)
      naddr = '0;
  end

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      state       <= MODE8;
      mode4       <= 1'b0;
      byte_valid  <= 1'b0;
      byte_out    <= '0;
      byte_rs     <= 1'b0;
      ddram_addr  <= '0;
      read_seen   <= 1'b0;
      err_width   <= 1'b0;
      err_timeout <= 1'b0;
      tcnt        <= '0;
      hi          <= '0;
      pend_rs     <= 1'b0;
    end else begin
      byte_valid <= done;
      read_seen  <= rd;
      if (short_e)
        err_width <= 1'b1;
      if (done) begin
        byte_out   <= nbyte;
        byte_rs    <= nrs;
        ddram_addr <= naddr;
      end
      case (state)
        MODE8: begin
          if (wr && !rs_s2 && nbyte == 8'h20) begin
            state <= M4_HI;
            mode4 <= 1'b1;
          end
        end
        M4_HI: begin
          if (wr) begin
            hi      <= dat_s2;
            pend_rs <= rs_s2;
            tcnt    <= '0;
            state   <= M4_LO;
          end
        end
        M4_LO: begin
          // A strobe landing on the timeout cycle still completes the byte.
          if (wr) begin
            if (!pend_rs && hi == 4'h3) begin
              state <= MODE8;
              mode4 <= 1'b0;
            end else begin
              state <= M4_HI;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(NIB_TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              state       <= M4_HI;
            end
          end
        end
        default: begin
          state <= MODE8;
          mode4 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: directed and random LCD bus strobes compared against a
// byte-level model of the display protocol.
module tb_lcd_bus_decoder;

  localparam int unsigned MIN_E = 4;
  localparam int unsigned NTO   = 20;

  logic       CCLK = 1'b0;
  logic       rst;
  logic       LCDE, LCDRS, LCDRW;
  logic [3:0] LCDDAT;
  logic       byte_valid, byte_rs, mode4, read_seen, err_width, err_timeout;
  logic [7:0] byte_out;
  logic [6:0] ddram_addr;

  int checks = 0;
  int errors = 0;

  lcd_bus_decoder #(.MIN_E_HIGH(MIN_E), .NIB_TIMEOUT(NTO)) dut (
    .CCLK(CCLK), .rst(rst), .LCDE(LCDE), .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDDAT(LCDDAT),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs), .mode4(mode4),
    .ddram_addr(ddram_addr), .read_seen(read_seen), .err_width(err_width),
    .err_timeout(err_timeout)
  );

  always #5 CCLK = ~CCLK;

  // Reference model of the display: mode, pending high nibble, address, error flags.
  logic       m_mode4, m_have, m_hrs, m_errw, m_errt;
  logic [3:0] m_hi;
  int         m_addr;

  task automatic model_reset();
    m_mode4 = 0; m_have = 0; m_hrs = 0; m_hi = 0; m_addr = 0; m_errw = 0; m_errt = 0;
  endtask

  task automatic model_strobe(input logic rs, input logic rw, input logic [3:0] d,
                              input int unsigned w, output int ev, output int er,
                              output int eb, output logic ers);
    ev = 0; er = 0; eb = 0; ers = 0;
    if (w < MIN_E) begin m_errw = 1; return; end
    if (rw) begin er = 1; return; end
    if (!m_mode4) begin
      eb = d * 16; ers = rs; ev = 1;
    end else if (!m_have) begin
      m_have = 1; m_hi = d; m_hrs = rs; return;
    end else begin
      eb = m_hi * 16 + d; ers = m_hrs; ev = 1; m_have = 0;
    end
    if (ers) m_addr = (m_addr + 1) % 128;
    else if (eb >= 128) m_addr = eb - 128;
    else if (eb >= 1 && eb <= 3) m_addr = 0;
    if (!ers && eb == 32) m_mode4 = 1;
    if (!ers && eb / 16 == 3) m_mode4 = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one strobe starting just after a falling clock edge, then watches for pulses.
  task automatic drive(input logic rs, input logic rw, input logic [3:0] d, input int unsigned w,
                       output int pv, output int pr, output logic [7:0] b,
                       output logic brs, output logic [6:0] a);
    pv = 0; pr = 0; b = 0; brs = 0; a = 0;
    LCDRS = rs; LCDRW = rw; LCDDAT = d; LCDE = 1'b1;
    repeat (w) @(negedge CCLK);
    LCDE = 1'b0;
    repeat (3) begin
      @(negedge CCLK);
      if (byte_valid) begin pv++; b = byte_out; brs = byte_rs; a = ddram_addr; end
      if (read_seen) pr++;
    end
  endtask

  task automatic step(input string tag, input logic rs, input logic rw, input logic [3:0] d,
                      input int unsigned w);
    int pv, pr, ev, er, eb;
    logic [7:0] b; logic brs, ers; logic [6:0] a;
    model_strobe(rs, rw, d, w, ev, er, eb, ers);
    drive(rs, rw, d, w, pv, pr, b, brs, a);
    check({tag, ".valid_pulses"}, pv, ev);
    check({tag, ".read_pulses"}, pr, er);
    if (ev != 0) begin
      check({tag, ".byte_out"}, b, eb);
      check({tag, ".byte_rs"}, brs, ers);
      check({tag, ".ddram_addr"}, a, m_addr);
    end
    check({tag, ".mode4"}, mode4, m_mode4);
    check({tag, ".err_width"}, err_width, m_errw);
  endtask

  task automatic idle(input int n, output int pv);
    pv = 0;
    repeat (n) begin
      @(negedge CCLK);
      if (byte_valid) pv++;
    end
    if (m_mode4 && m_have && n > NTO + 5) begin m_have = 0; m_errt = 1; end
  endtask

  initial begin
    int pv;
    logic rs;
    logic [3:0] d;
    rst = 1'b1; LCDE = 1'b0; LCDRS = 1'b0; LCDRW = 1'b0; LCDDAT = 4'h0;
    model_reset();
    repeat (3) @(negedge CCLK);
    check("reset_outputs", {byte_valid, byte_out, byte_rs, mode4, ddram_addr, read_seen,
                            err_width, err_timeout}, '0);
    rst = 1'b0;
    @(negedge CCLK);

    step("init1", 0, 0, 4'h3, 6);
    step("init2", 0, 0, 4'h3, 6);
    step("init3", 0, 0, 4'h3, 6);
    step("init4", 0, 0, 4'h2, 6);
    check("init_mode4", mode4, 1'b1);

    step("cmd85_hi", 0, 0, 4'h8, 5);
    step("cmd85_lo", 0, 0, 4'h5, 5);
    step("dat41_hi", 1, 0, 4'h4, 5);
    step("dat41_lo", 1, 0, 4'h1, 5);

    step("set7f_hi", 0, 0, 4'hF, 5);
    step("set7f_lo", 0, 0, 4'hF, 5);
    step("wrap_hi", 1, 0, 4'hA, 5);
    step("wrap_lo", 1, 0, 4'h5, 5);
    check("wrap_addr_zero", ddram_addr, 7'h00);

    step("short_e", 0, 0, 4'h9, 2);
    check("short_err_width", err_width, 1'b1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0)
        step("rand_read", 1'($urandom_range(1)), 1, 4'($urandom_range(15)), 5);
      rs = 1'($urandom_range(1));
      d  = 4'($urandom_range(15));
      step("rand_wr", rs, 0, d, 5);
    end

    if (m_have) step("flush_lo", 1, 0, 4'h0, 5);
    if (!m_mode4) step("back_to4", 0, 0, 4'h2, 6);
    check("pre_timeout_mode4", mode4, 1'b1);
    step("to_hi", 1, 0, 4'h7, 5);
    idle(30, pv);
    check("timeout_no_valid", pv, 0);
    check("timeout_err", err_timeout, m_errt);
    check("timeout_mode4", mode4, 1'b1);
    step("after_to_hi", 0, 0, 4'h0, 5);
    step("after_to_lo", 0, 0, 4'h1, 5);
    check("clear_addr", ddram_addr, 7'h00);

    step("rd_mid_hi", 0, 0, 4'h8, 5);
    step("rd_mid_read", 0, 1, 4'hC, 5);
    step("rd_mid_lo", 0, 0, 4'h3, 5);
    check("rd_mid_addr", ddram_addr, 7'h03);

    step("rst_mid_hi", 1, 0, 4'h5, 5);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {byte_valid, byte_out, byte_rs, mode4, ddram_addr, read_seen,
                                err_width, err_timeout}, '0);
    model_reset();
    @(negedge CCLK);
    rst = 1'b0;
    @(negedge CCLK);
    check("rst_released_outputs", {byte_valid, byte_out, byte_rs, mode4, ddram_addr, read_seen,
                                   err_width, err_timeout}, '0);
    step("post_rst_mode8", 0, 0, 4'h3, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_bus_decoder.md
# lcd_bus_decoder

Synthesizable receiver for the 4-bit HD44780-style character-LCD bus (LCDE, LCDRS, LCDRW, LCDDAT) that mips_top drives. It watches the bus from the display side, reassembles nibbles into command/data bytes, tracks the display's DDRAM address and flags protocol violations. It sits beside mips_top in simulation and on the board, for checking LCD traffic without a physical panel.

## Interface
- MIN_E_HIGH, 4: minimum LCDE high time, in CCLK cycles, for a strobe to be accepted.
- NIB_TIMEOUT, 65535: maximum CCLK cycles allowed between the high and low nibble of one byte; must be ≥ 1.
- CCLK  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- LCDE  in  1  LCD enable strobe; asynchronous to CCLK.
- LCDRS  in  1  register select: 0 = command, 1 = data.
- LCDRW  in  1  1 = read cycle; 0 = write cycle.
- LCDDAT  in  4  LCD data nibble (D7..D4).
- byte_valid  out  1  one-cycle pulse: byte_out/byte_rs hold a completed write.
- byte_out  out  8  last completed byte.
- byte_rs  out  1  RS value of that byte.
- mode4  out  1  1 = 4-bit interface mode active.
- ddram_addr  out  7  tracked display address.
- read_seen  out  1  one-cycle pulse on every accepted read strobe.
- err_width  out  1  sticky: an LCDE pulse shorter than MIN_E_HIGH occurred.
- err_timeout  out  1  sticky: a low nibble failed to arrive within NIB_TIMEOUT.

## Operation
- Input capture: LCDE, LCDRS, LCDRW and LCDDAT each pass through a two-flop synchronizer. A third flop on synchronized LCDE detects edges. A falling edge is synchronized E = 0 with the previous value = 1.
- Width counter: counts CCLK cycles while synchronized E = 1 and saturates at MIN_E_HIGH. At a falling edge, a count below MIN_E_HIGH means the strobe is discarded with no state change except err_width ← 1.
- For an accepted strobe, RS, RW and DAT are taken from the synchronized copies in the detect cycle.
- RW = 1 strobe: read_seen pulses. No byte is formed, and the nibble phase is unchanged.
- States: MODE8, M4_HI, M4_LO.
  - MODE8: each write strobe completes a byte {DAT, 4'b0000}, and byte_valid pulses. If that byte is command 0x20, the block moves to M4_HI.
  - M4_HI: a write strobe latches DAT as the high nibble and RS as pending RS, then moves to M4_LO. The timeout counter clears.
  - M4_LO: a write strobe completes the byte {hi, DAT}, and byte_valid pulses with the pending RS. The block then moves to M4_HI. A mismatch between the RS of the two nibbles does not raise an error; the first nibble's RS wins.
  - M4_LO: the timeout counter increments every cycle. When it reaches NIB_TIMEOUT with no strobe, the high nibble is dropped, err_timeout ← 1, and the block moves to M4_HI.
  - Completed command byte with bits[7:4] = 0x3 (function set, DL = 1): the block moves to MODE8.
- mode4 = 1 in M4_HI and M4_LO.
- DDRAM tracking, applied only on a completed byte:
  - Command 0x01 (clear) → addr 0.
  - Command 0x02/0x03 (home) → addr 0.
  - Command with bit7 = 1 → addr byte[6:0].
  - Data byte → addr + 1, 7-bit wrap (0x7F → 0x00).
  - Other commands leave the address unchanged.
- err flags clear only on rst.

## Timing
- Reset values:
  - byte_valid = 0, byte_out = 0x00, byte_rs = 0.
  - mode4 = 0 (state MODE8), ddram_addr = 0.
  - read_seen = 0, err_width = 0, err_timeout = 0.
  - Synchronizers = 0, width and timeout counters = 0, high-nibble register = 0.
- Latency: LCDE low first sampled at CCLK edge k causes the outputs (byte_valid, byte_out, state, ddram_addr) to update at edge k+2. byte_valid is high for exactly the cycle that follows that edge.
- ddram_addr, mode4 and byte_out update on the same edge as byte_valid.
- LCDRS/LCDRW/LCDDAT must be stable for ≥ 3 CCLK cycles around the LCDE fall.
- Simultaneous events:
  - Falling edge in the same cycle the timeout count reaches NIB_TIMEOUT: the strobe wins as a valid low nibble, and err_timeout is not set.
  - A too-short strobe in M4_LO does not reset the timeout counter.
- rst asserted mid-byte: the pending nibble is lost, the state returns to MODE8, and all outputs immediately take their reset values.

## Test plan
- Reset then init sequence: RS = 0 writes of 0x3, 0x3, 0x3, 0x2 (MIN_E_HIGH = 4, E high 6 cycles). Required: byte_out = 0x30, 0x30, 0x30, 0x20 with four byte_valid pulses, and mode4 = 1 after the fourth.
- In 4-bit mode:
  - Command nibbles 0x8, 0x5 → byte_out = 0x85, byte_rs = 0, ddram_addr = 0x05.
  - Then data nibbles 0x4, 0x1 → byte_out = 0x41, byte_rs = 1, ddram_addr = 0x06.
- Starting from ddram_addr 0x7F, a data byte → ddram_addr = 0x00.
- E pulse 2 cycles wide → err_width = 1, no byte_valid, state unchanged.
- Low nibble missing:
  - NIB_TIMEOUT = 20, one high nibble followed by 20 idle cycles → err_timeout = 1, state M4_HI.
  - The next nibble pair 0x0, 0x1 → byte_out = 0x01, ddram_addr = 0.
- RW = 1 strobe between two nibbles → read_seen pulses, and the following nibble still completes the byte.
- rst pulsed in M4_LO → mode4 = 0, all outputs at reset values.
